// File: rtl/echo_pkg.sv
// Shared types and default constants for the echo tap scheduler.
package echo_pkg;

   localparam int unsigned DEPTH_DEF   = 18000;
   localparam int unsigned DELAY1_DEF  = 1500;
   localparam int unsigned DELAY2_DEF  = 3000;
   localparam int unsigned RAM_LAT_DEF = 2;

   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 8;
   localparam int unsigned ACC_W = 10;

   typedef enum logic [2:0] {IDLE, TAP0, TAP1, TAP2, DRAIN, OUT} state_t;

   // Tag travelling alongside an outstanding read; live=0 means the tap contributes 0.
   typedef struct packed {
      logic       live;
      logic [1:0] tap;
   } tap_tag_t;

   // Clamp the wide accumulator into the signed 8-bit sample range.
   function automatic logic signed [DW-1:0] sat_mix(input logic signed [ACC_W-1:0] v);
      if (v > 10'sd127)
         return 8'sd127;
      else if (v < -10'sd128)
         return -8'sd128;
      else
         return DW'(v);
   endfunction

endpackage

// File: rtl/echo_tap_scheduler.sv
// Records samples into an external buffer and, on each playback strobe,
// mixes the current sample with two delayed echo taps read back from it.
module echo_tap_scheduler
   import echo_pkg::*;
#(
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned DELAY1  = DELAY1_DEF,
   parameter int unsigned DELAY2  = DELAY2_DEF,
   parameter int unsigned RAM_LAT = RAM_LAT_DEF
)(
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic signed [DW-1:0] audio_in,
   input  logic                 audio_valid_in,
   input  logic                 record_in,
   output logic                 ram_we_out,
   output logic [AW-1:0]        ram_waddr_out,
   output logic [DW-1:0]        ram_wdata_out,
   output logic [AW-1:0]        ram_raddr_out,
   input  logic signed [DW-1:0] ram_rdata_in,
   output logic signed [DW-1:0] mix_out,
   output logic                 mix_valid_out,
   output logic [AW-1:0]        rec_len_out,
   output logic                 busy_out,
   output logic                 finish_out,
   output logic                 overrun_out
);

   state_t                    state;
   logic                      record_d;
   logic [AW-1:0]             rec_len;
   logic [AW-1:0]             play_addr;
   logic signed [ACC_W-1:0]   acc;
   tap_tag_t [RAM_LAT-1:0]    pipe;
   logic [7:0]                drain_cnt;

   logic                      rec_rise;
   logic                      wr_en;
   logic [AW-1:0]             wr_addr;
   logic                      mask1;
   logic                      mask2;
   tap_tag_t                  head;
   logic signed [ACC_W-1:0]   tap_val;
   logic signed [ACC_W-1:0]   acc_sum;

   assign rec_len_out = rec_len;

   // Write port, tap masking and the contribution of the read returning this cycle.
   always_comb begin
      rec_rise      = record_in & ~record_d;
      wr_addr       = rec_rise ? '0 : rec_len;
      wr_en         = rst_in & record_in & audio_valid_in & (wr_addr < AW'(DEPTH));
      ram_we_out    = wr_en;
      ram_waddr_out = wr_en ? wr_addr : '0;
      ram_wdata_out = wr_en ? audio_in : '0;
      mask1         = AW'(DELAY1) > play_addr;
      mask2         = AW'(DELAY2) > play_addr;
      head          = pipe[RAM_LAT-1];
      tap_val       = '0;
      if (head.live) begin
         case (head.tap)
            2'd0:    tap_val = ACC_W'(ram_rdata_in);
            2'd1:    tap_val = ACC_W'(ram_rdata_in) >>> 1;
            default: tap_val = ACC_W'(ram_rdata_in) >>> 2;
         endcase
      end
      acc_sum = acc + tap_val;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state         <= IDLE;
         record_d      <= 1'b0;
         rec_len       <= '0;
         play_addr     <= '0;
         acc           <= '0;
         pipe          <= '0;
         drain_cnt     <= '0;
         mix_out       <= '0;
         mix_valid_out <= 1'b0;
         busy_out      <= 1'b0;
         finish_out    <= 1'b0;
         overrun_out   <= 1'b0;
         ram_raddr_out <= '0;
      end else begin
         record_d      <= record_in;
         finish_out    <= record_d & ~record_in & (rec_len != '0);
         mix_valid_out <= 1'b0;
         acc           <= acc_sum;

         if (wr_en)
            rec_len <= wr_addr + AW'(1);
         else if (rec_rise)
            rec_len <= '0;

         if (audio_valid_in && !record_in && busy_out)
            overrun_out <= 1'b1;

         // Tags age in step with the buffer read latency.
         for (int i = RAM_LAT - 1; i > 0; i--)
            pipe[i] <= pipe[i-1];
         pipe[0] <= '0;

         unique case (state)
            IDLE: begin
               if (audio_valid_in && !record_in && rec_len != '0) begin
                  state         <= TAP0;
                  busy_out      <= 1'b1;
                  ram_raddr_out <= play_addr;
                  acc           <= '0;
               end
            end
            TAP0: begin
               pipe[0]       <= '{live: 1'b1, tap: 2'd0};
               ram_raddr_out <= mask1 ? '0 : play_addr - AW'(DELAY1);
               state         <= TAP1;
            end
            TAP1: begin
               pipe[0]       <= '{live: ~mask1, tap: 2'd1};
               ram_raddr_out <= mask2 ? '0 : play_addr - AW'(DELAY2);
               state         <= TAP2;
            end
            TAP2: begin
               pipe[0]       <= '{live: ~mask2, tap: 2'd2};
               ram_raddr_out <= '0;
               drain_cnt     <= 8'(RAM_LAT - 2);
               state         <= (RAM_LAT > 1) ? DRAIN : OUT;
            end
            DRAIN: begin
               if (drain_cnt == '0)
                  state <= OUT;
               else
                  drain_cnt <= drain_cnt - 8'(1);
            end
            OUT: begin
               mix_out       <= sat_mix(acc_sum);
               mix_valid_out <= 1'b1;
               play_addr     <= (play_addr + AW'(1) == rec_len) ? '0 : play_addr + AW'(1);
               busy_out      <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               busy_out <= 1'b0;
               state    <= IDLE;
            end
         endcase

         // Recording pre-empts playback; a new recording restarts playback from the top.
         if (record_in && state != IDLE) begin
            state         <= IDLE;
            busy_out      <= 1'b0;
            mix_valid_out <= 1'b0;
            pipe          <= '0;
            ram_raddr_out <= '0;
         end
         if (rec_rise)
            play_addr <= '0;
      end
   end

endmodule

// File: tb/tb_echo_tap_scheduler.sv
// Self-checking bench: behavioural 2-cycle RAM plus an arithmetic echo-mix reference.
module tb_echo_tap_scheduler;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned D1    = 1;
   localparam int unsigned D2    = 2;
   localparam int unsigned LAT   = 2;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic signed [7:0] audio_in;
   logic              audio_valid_in;
   logic              record_in;
   logic              ram_we_out;
   logic [15:0]       ram_waddr_out;
   logic [7:0]        ram_wdata_out;
   logic [15:0]       ram_raddr_out;
   logic signed [7:0] ram_rdata_in;
   logic signed [7:0] mix_out;
   logic              mix_valid_out;
   logic [15:0]       rec_len_out;
   logic              busy_out;
   logic              finish_out;
   logic              overrun_out;

   always #5 clk_in = ~clk_in;

   echo_tap_scheduler #(.DEPTH(DEPTH), .DELAY1(D1), .DELAY2(D2), .RAM_LAT(LAT)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .audio_in(audio_in), .audio_valid_in(audio_valid_in),
      .record_in(record_in), .ram_we_out(ram_we_out), .ram_waddr_out(ram_waddr_out),
      .ram_wdata_out(ram_wdata_out), .ram_raddr_out(ram_raddr_out), .ram_rdata_in(ram_rdata_in),
      .mix_out(mix_out), .mix_valid_out(mix_valid_out), .rec_len_out(rec_len_out),
      .busy_out(busy_out), .finish_out(finish_out), .overrun_out(overrun_out)
   );

   // Behavioural buffer RAM with two-cycle read latency.
   logic [7:0] mem [0:65535];
   logic [7:0] rd_s1, rd_s2;
   always @(posedge clk_in) begin
      if (ram_we_out) mem[ram_waddr_out] <= ram_wdata_out;
      rd_s1 <= mem[ram_raddr_out];
      rd_s2 <= rd_s1;
   end
   assign ram_rdata_in = rd_s2;

   int  n_cmp = 0;
   int  n_bad = 0;
   int  ref_mem [0:DEPTH-1];
   int  ref_len = 0;
   int  ref_play = 0;
   byte samp_q[$];

   function automatic int exp_mix(input int p);
      int s;
      s = ref_mem[p];
      if (p >= int'(D1)) s += ref_mem[p - int'(D1)] >>> 1;
      if (p >= int'(D2)) s += ref_mem[p - int'(D2)] >>> 2;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      return s;
   endfunction

   task automatic record_seq();
      int   nfin;
      logic exp_we;
      @(posedge clk_in); #1;
      record_in = 1'b1; audio_valid_in = 1'b0;
      @(posedge clk_in); #1;
      for (int i = 0; i < samp_q.size(); i++) begin
         audio_valid_in = 1'b1; audio_in = samp_q[i];
         exp_we = (i < int'(DEPTH));
         @(negedge clk_in);
         n_cmp++; if (ram_we_out !== exp_we) begin n_bad++; $display("FAIL wr_we[%0d] got %0b want %0b", i, ram_we_out, exp_we); end
         if (exp_we) begin
            n_cmp++; if (ram_waddr_out !== 16'(i)) begin n_bad++; $display("FAIL wr_addr[%0d] got %0d want %0d", i, ram_waddr_out, i); end
            n_cmp++; if (ram_wdata_out !== 8'(samp_q[i])) begin n_bad++; $display("FAIL wr_data[%0d] got %0d want %0d", i, $signed(ram_wdata_out), samp_q[i]); end
            ref_mem[i] = int'(samp_q[i]);
         end
         @(posedge clk_in); #1;
      end
      ref_len = (samp_q.size() < int'(DEPTH)) ? samp_q.size() : int'(DEPTH);
      audio_valid_in = 1'b0; record_in = 1'b0;
      nfin = 0;
      repeat (4) begin @(negedge clk_in); if (finish_out) nfin++; end
      n_cmp++; if (nfin !== (ref_len > 0 ? 1 : 0)) begin n_bad++; $display("FAIL finish_pulses got %0d want %0d", nfin, ref_len > 0 ? 1 : 0); end
      n_cmp++; if (rec_len_out !== 16'(ref_len)) begin n_bad++; $display("FAIL rec_len got %0d want %0d", rec_len_out, ref_len); end
   endtask

   // One playback strobe, optional extra strobe / record raise at cycle offsets; observes 10 cycles.
   task automatic trigger(input int extra_at, input int rec_at, output int n, output int lat,
                          output logic [7:0] val, output logic busy0, output logic busy1,
                          output logic [15:0] ra1, output logic [15:0] ra2, output logic [15:0] ra3);
      n = 0; lat = -1; val = '0; busy0 = 1'b0; busy1 = 1'b0; ra1 = '0; ra2 = '0; ra3 = '0;
      @(posedge clk_in); #1;
      audio_valid_in = 1'b1; record_in = 1'b0; audio_in = 8'sd0;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk_in);
         if (k == 0) busy0 = busy_out;
         if (k == 1) begin busy1 = busy_out; ra1 = ram_raddr_out; end
         if (k == 2) ra2 = ram_raddr_out;
         if (k == 3) ra3 = ram_raddr_out;
         if (mix_valid_out) begin n++; lat = k; val = mix_out; end
         @(posedge clk_in); #1;
         audio_valid_in = (k + 1 == extra_at);
         if (rec_at > 0 && k + 1 >= rec_at) record_in = 1'b1;
      end
      audio_valid_in = 1'b0;
   endtask

   task automatic play_check(input string tag);
      int n, lat, e;
      logic [7:0] val;
      logic b0, b1;
      logic [15:0] ra1, ra2, ra3;
      e = exp_mix(ref_play);
      trigger(0, 0, n, lat, val, b0, b1, ra1, ra2, ra3);
      n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL %s mix_count got %0d want 1", tag, n); end
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL %s latency got %0d want 6", tag, lat); end
      n_cmp++; if (val !== 8'(e)) begin n_bad++; $display("FAIL %s mix p=%0d got %0d want %0d", tag, ref_play, $signed(val), e); end
      n_cmp++; if (b0 !== 1'b0 || b1 !== 1'b1) begin n_bad++; $display("FAIL %s busy got %0b%0b want 01", tag, b0, b1); end
      n_cmp++; if (ra1 !== 16'(ref_play)) begin n_bad++; $display("FAIL %s raddr0 got %0d want %0d", tag, ra1, ref_play); end
      if (ref_play >= int'(D1)) begin
         n_cmp++; if (ra2 !== 16'(ref_play - int'(D1))) begin n_bad++; $display("FAIL %s raddr1 got %0d want %0d", tag, ra2, ref_play - int'(D1)); end
      end
      if (ref_play >= int'(D2)) begin
         n_cmp++; if (ra3 !== 16'(ref_play - int'(D2))) begin n_bad++; $display("FAIL %s raddr2 got %0d want %0d", tag, ra3, ref_play - int'(D2)); end
      end
      ref_play = (ref_play + 1 == ref_len) ? 0 : ref_play + 1;
   endtask

   task automatic test_reset();
      rst_in = 1'b0; record_in = 1'b1; audio_valid_in = 1'b1; audio_in = 8'sd55;
      repeat (3) @(negedge clk_in);
      n_cmp++; if ({ram_we_out, ram_waddr_out, ram_wdata_out, ram_raddr_out} !== 41'd0) begin n_bad++; $display("FAIL rst_ram got we=%0b wa=%0d wd=%0d ra=%0d want 0", ram_we_out, ram_waddr_out, ram_wdata_out, ram_raddr_out); end
      n_cmp++; if ({mix_out, mix_valid_out, rec_len_out} !== 25'd0) begin n_bad++; $display("FAIL rst_mix got mix=%0d v=%0b len=%0d want 0", mix_out, mix_valid_out, rec_len_out); end
      n_cmp++; if ({busy_out, finish_out, overrun_out} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b want 000", {busy_out, finish_out, overrun_out}); end
      record_in = 1'b0; audio_valid_in = 1'b0; audio_in = 8'sd0;
      @(negedge clk_in); #2 rst_in = 1'b1;
      ref_len = 0; ref_play = 0;
   endtask

   task automatic test_record();
      samp_q = '{8'sd10, 8'sd20, 8'sd30, 8'sd40};
      record_seq();
      for (int i = 0; i < 8; i++) play_check($sformatf("rec4_play%0d", i));
   endtask

   task automatic test_saturate();
      samp_q = '{8'sd100, 8'sd100, 8'sd100};
      record_seq();
      for (int i = 0; i < 3; i++) play_check($sformatf("sat_pos%0d", i));
      samp_q = '{-8'sd100, -8'sd100, -8'sd100};
      record_seq();
      for (int i = 0; i < 3; i++) play_check($sformatf("sat_neg%0d", i));
   endtask

   task automatic test_full();
      samp_q.delete();
      for (int i = 0; i < 20; i++) samp_q.push_back(byte'(i * 7 - 60));
      record_seq();
   endtask

   task automatic test_overrun();
      int n, lat, e;
      logic [7:0] val;
      logic b0, b1;
      logic [15:0] ra1, ra2, ra3;
      n_cmp++; if (overrun_out !== 1'b0) begin n_bad++; $display("FAIL ovr_pre got %0b want 0", overrun_out); end
      e = exp_mix(ref_play);
      trigger(2, 0, n, lat, val, b0, b1, ra1, ra2, ra3);
      n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL ovr_mix_count got %0d want 1", n); end
      n_cmp++; if (val !== 8'(e) || lat !== 6) begin n_bad++; $display("FAIL ovr_mix got %0d@%0d want %0d@6", $signed(val), lat, e); end
      ref_play = (ref_play + 1 == ref_len) ? 0 : ref_play + 1;
      n_cmp++; if (overrun_out !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %0b want 1", overrun_out); end
      play_check("ovr_next");
      n_cmp++; if (overrun_out !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %0b want 1", overrun_out); end
   endtask

   task automatic test_reset_mid();
      int n, lat, nmix;
      logic [7:0] val;
      logic b0, b1;
      logic [15:0] ra1, ra2, ra3;
      @(posedge clk_in); #1 audio_valid_in = 1'b1;
      @(posedge clk_in); #1 audio_valid_in = 1'b0;
      @(posedge clk_in); #2;
      n_cmp++; if (busy_out !== 1'b1) begin n_bad++; $display("FAIL rmid_busy got %0b want 1", busy_out); end
      rst_in = 1'b0; #1;
      n_cmp++; if ({busy_out, mix_valid_out, overrun_out, finish_out, ram_we_out} !== 5'd0) begin n_bad++; $display("FAIL rmid_flags got %b want 00000", {busy_out, mix_valid_out, overrun_out, finish_out, ram_we_out}); end
      n_cmp++; if ({mix_out, ram_raddr_out, rec_len_out, ram_waddr_out, ram_wdata_out} !== 64'd0) begin n_bad++; $display("FAIL rmid_buses got mix=%0d ra=%0d len=%0d want 0", mix_out, ram_raddr_out, rec_len_out); end
      ref_len = 0; ref_play = 0;
      repeat (2) @(posedge clk_in);
      #2 rst_in = 1'b1;
      nmix = 0;
      repeat (10) begin @(negedge clk_in); if (mix_valid_out) nmix++; end
      n_cmp++; if (nmix !== 0) begin n_bad++; $display("FAIL rmid_no_mix got %0d want 0", nmix); end
      trigger(0, 0, n, lat, val, b0, b1, ra1, ra2, ra3);
      n_cmp++; if (n !== 0 || b1 !== 1'b0) begin n_bad++; $display("FAIL empty_play got n=%0d busy=%0b want 0/0", n, b1); end
   endtask

   task automatic test_abort();
      int n, lat, nfin;
      logic [7:0] val;
      logic b0, b1;
      logic [15:0] ra1, ra2, ra3;
      samp_q = '{8'sd5, 8'sd6, 8'sd7};
      record_seq();
      play_check("abort_pre");
      trigger(0, 2, n, lat, val, b0, b1, ra1, ra2, ra3);
      n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL abort_mix got %0d want 0", n); end
      record_in = 1'b0;
      ref_len = 0; ref_play = 0;
      nfin = 0;
      repeat (4) begin @(negedge clk_in); if (finish_out) nfin++; end
      n_cmp++; if (nfin !== 0 || rec_len_out !== 16'd0) begin n_bad++; $display("FAIL abort_len got fin=%0d len=%0d want 0/0", nfin, rec_len_out); end
      samp_q = '{8'sd9, 8'sd8, 8'sd7};
      record_seq();
      for (int i = 0; i < 3; i++) play_check($sformatf("abort_post%0d", i));
   endtask

   task automatic test_random();
      int n;
      n = $urandom_range(2, 16);
      samp_q.delete();
      for (int i = 0; i < n; i++) samp_q.push_back(byte'($urandom_range(0, 255)));
      record_seq();
      for (int i = 0; i < 2 * n + 3; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk_in);
         play_check($sformatf("rand%0d", i));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst_in = 1'b0; audio_in = '0; audio_valid_in = 1'b0; record_in = 1'b0;
      test_reset();
      test_record();
      test_saturate();
      test_full();
      test_overrun();
      test_reset_mid();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
